pc_sequencer: RTL and testbench

Parametrised program counter for the single-cycle/multicycle datapath. It replaces the fixed-width, initial-block-only PC. It generates the fetch address and adds:
- sequential increment
- branch and jump redirect
- stall hold, with a pending-redirect buffer
- trap entry, with a saved exception PC, and trap return
- misaligned-target detection

It sits between the next-address logic and instruction memory, and feeds PC+step back to the link/branch adders.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter with sequential increment, branch/jump redirect, stall with a
// pending-redirect buffer, trap entry/return and misaligned-target trapping.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h00001000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h00000080,
  parameter int               STEP         = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Trap,
  input  logic             TrapReturn,
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] PCPlus,
  output logic [WIDTH-1:0] EPC,
  output logic             Valid,
  output logic             Misaligned
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - 1'b1;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;

  logic             req_valid;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] load_target;
  logic             load_bad;

  assign PCPlus = PCOut + STEP_W;

  // Redirect request priority: TrapReturn > Jump > BranchTaken.
  always_comb begin
    req_valid  = TrapReturn | Jump | BranchTaken;
    req_target = BranchTarget;
    if (TrapReturn) begin
      req_target = EPC;
    end else if (Jump) begin
      req_target = JumpTarget;
    end
  end

  // The target that would load this edge: the buffered one when leaving HOLD.
  always_comb begin
    load_target = (state == HOLD) ? pending : req_target;
    load_bad    = |(load_target & ALIGN_MASK);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= BOOT;
      PCOut      <= RESET_VECTOR;
      EPC        <= '0;
      Valid      <= 1'b0;
      Misaligned <= 1'b0;
      pending    <= '0;
    end else begin
      Misaligned <= 1'b0;
      case (state)
        BOOT: begin
          state <= RUN;
          Valid <= 1'b1;
        end
        RUN: begin
          if (Trap) begin
            PCOut <= TRAP_VECTOR;
            EPC   <= PCOut;
          end else if (Stall) begin
            if (req_valid) begin
              pending <= req_target;
              state   <= HOLD;
            end
          end else if (req_valid) begin
            if (load_bad) begin
              PCOut      <= TRAP_VECTOR;
              EPC        <= PCOut;
              Misaligned <= 1'b1;
            end else begin
              PCOut <= load_target;
            end
          end else begin
            PCOut <= PCPlus;
          end
        end
        HOLD: begin
          if (Trap) begin
            PCOut   <= TRAP_VECTOR;
            EPC     <= PCOut;
            pending <= '0;
            state   <= RUN;
          end else if (Stall) begin
            if (req_valid) begin
              pending <= req_target;
            end
          end else begin
            if (load_bad) begin
              PCOut      <= TRAP_VECTOR;
              EPC        <= PCOut;
              Misaligned <= 1'b1;
            end else begin
              PCOut <= load_target;
            end
            pending <= '0;
            state   <= RUN;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit default instance and an 8-bit
// instance for wrap-around and asynchronous reset during HOLD.
module tb_pc_sequencer;

  typedef struct {
    bit          sel;
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        valid;
    logic        mis;
  } exp_t;

  logic        Clk;
  logic        rst32, rst8;
  logic        Stall, BranchTaken, Jump, Trap, TrapReturn;
  logic [31:0] BranchTarget, JumpTarget;

  logic [31:0] pc32, plus32, epc32;
  logic        valid32, mis32;
  logic [7:0]  pc8, plus8, epc8;
  logic        valid8, mis8;

  exp_t sbq[$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  pc_sequencer dut32 (
    .Clk(Clk), .Rst_n(rst32), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .Trap(Trap), .TrapReturn(TrapReturn),
    .PCOut(pc32), .PCPlus(plus32), .EPC(epc32),
    .Valid(valid32), .Misaligned(mis32)
  );

  pc_sequencer #(
    .WIDTH(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .STEP(4)
  ) dut8 (
    .Clk(Clk), .Rst_n(rst8), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget[7:0]),
    .Jump(Jump), .JumpTarget(JumpTarget[7:0]),
    .Trap(Trap), .TrapReturn(TrapReturn),
    .PCOut(pc8), .PCPlus(plus8), .EPC(epc8),
    .Valid(valid8), .Misaligned(mis8)
  );

  always #5 Clk = ~Clk;

  task automatic pushExp(input string nm, input bit sel, input logic [31:0] pc,
                         input logic [31:0] epc, input logic v, input logic m);
    exp_t e;
    e.sel = sel; e.name = nm; e.pc = pc; e.epc = epc; e.valid = v; e.mis = m;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] aPc, aPlus, aEpc, wPlus;
    logic        aV, aM;
    if (!e.sel) begin
      aPc = pc32; aPlus = plus32; aEpc = epc32; aV = valid32; aM = mis32;
      wPlus = e.pc + 32'd4;
    end else begin
      aPc = {24'd0, pc8}; aPlus = {24'd0, plus8}; aEpc = {24'd0, epc8};
      aV = valid8; aM = mis8;
      wPlus = {24'd0, 8'(e.pc[7:0] + 8'd4)};
    end
    total++;
    if (aPc !== e.pc || aPlus !== wPlus || aEpc !== e.epc || aV !== e.valid || aM !== e.mis) begin
      bad++;
      $display("[TB] FAIL %s: pc=%h want %h pcplus=%h want %h epc=%h want %h valid=%b want %b mis=%b want %b",
               e.name, aPc, e.pc, aPlus, wPlus, aEpc, e.epc, aV, e.valid, aM, e.mis);
    end
  endtask

  // Monitor: every falling edge, check all expectations queued since the rising edge.
  always @(negedge Clk) begin
    while (sbq.size() > 0) begin
      monE = sbq.pop_front();
      checkOutput(monE);
    end
  end

  task automatic applyStimulus(input string nm, input bit sel, input logic st,
                               input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt,
                               input logic tr, input logic trt,
                               input logic [31:0] ePc, input logic [31:0] eEpc,
                               input logic eV, input logic eM);
    Stall = st; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
    Trap = tr; TrapReturn = trt;
    @(posedge Clk);
    #1;
    pushExp(nm, sel, ePc, eEpc, eV, eM);
  endtask

  initial begin
    Clk = 0; rst32 = 0; rst8 = 0;
    Stall = 0; BranchTaken = 0; Jump = 0; Trap = 0; TrapReturn = 0;
    BranchTarget = 0; JumpTarget = 0;
    #2;
    pushExp("rst32", 0, 32'h1000, 0, 0, 0);
    pushExp("rst8", 1, 32'hF8, 0, 0, 0);
    @(negedge Clk); #2 rst32 = 1;

    //            name          sel st br bt        jp jt        tr trt  pc        epc       v  m
    applyStimulus("boot",        0, 0, 0, 0,        0, 0,        0, 0, 'h1000, 0,       1, 0);
    applyStimulus("inc1",        0, 0, 0, 0,        0, 0,        0, 0, 'h1004, 0,       1, 0);
    applyStimulus("stall1jmp",   0, 1, 0, 0,        1, 'h4000,   0, 0, 'h1004, 0,       1, 0);
    applyStimulus("stall2",      0, 1, 0, 0,        0, 0,        0, 0, 'h1004, 0,       1, 0);
    applyStimulus("stall3",      0, 1, 0, 0,        0, 0,        0, 0, 'h1004, 0,       1, 0);
    applyStimulus("release",     0, 0, 0, 0,        0, 0,        0, 0, 'h4000, 0,       1, 0);
    applyStimulus("inc4004",     0, 0, 0, 0,        0, 0,        0, 0, 'h4004, 0,       1, 0);
    applyStimulus("jmp1008",     0, 0, 0, 0,        1, 'h1008,   0, 0, 'h1008, 0,       1, 0);
    applyStimulus("br+jmp",      0, 0, 1, 'h2000,   1, 'h3000,   0, 0, 'h3000, 0,       1, 0);
    applyStimulus("inc3004",     0, 0, 0, 0,        0, 0,        0, 0, 'h3004, 0,       1, 0);
    applyStimulus("branch100c",  0, 0, 1, 'h100C,   0, 0,        0, 0, 'h100C, 0,       1, 0);
    applyStimulus("trap",        0, 0, 0, 0,        0, 0,        1, 0, 'h80,   'h100C,  1, 0);
    applyStimulus("inc84",       0, 0, 0, 0,        0, 0,        0, 0, 'h84,   'h100C,  1, 0);
    applyStimulus("inc88",       0, 0, 0, 0,        0, 0,        0, 0, 'h88,   'h100C,  1, 0);
    applyStimulus("trapret",     0, 0, 0, 0,        0, 0,        0, 1, 'h100C, 'h100C,  1, 0);
    applyStimulus("trap+tret",   0, 0, 0, 0,        0, 0,        1, 1, 'h80,   'h100C,  1, 0);
    applyStimulus("nested",      0, 0, 0, 0,        0, 0,        1, 0, 'h80,   'h80,    1, 0);
    applyStimulus("jmp2000",     0, 0, 0, 0,        1, 'h2000,   0, 0, 'h2000, 'h80,    1, 0);
    applyStimulus("misjmp",      0, 0, 0, 0,        1, 'h2002,   0, 0, 'h80,   'h2000,  1, 1);
    applyStimulus("mispulse",    0, 0, 0, 0,        0, 0,        0, 0, 'h84,   'h2000,  1, 0);
    applyStimulus("stall+trap",  0, 1, 0, 0,        0, 0,        1, 0, 'h80,   'h84,    1, 0);
    applyStimulus("stallbr",     0, 1, 1, 'h3001,   0, 0,        0, 0, 'h80,   'h84,    1, 0);
    applyStimulus("latestwins",  0, 1, 0, 0,        1, 'h5000,   0, 0, 'h80,   'h84,    1, 0);
    applyStimulus("holdignore",  0, 0, 0, 0,        1, 'h6000,   0, 0, 'h5000, 'h84,    1, 0);
    applyStimulus("stallbrmis",  0, 1, 1, 'h3002,   0, 0,        0, 0, 'h5000, 'h84,    1, 0);
    applyStimulus("pendmis",     0, 0, 0, 0,        0, 0,        0, 0, 'h80,   'h5000,  1, 1);
    applyStimulus("pendpulse",   0, 0, 0, 0,        0, 0,        0, 0, 'h84,   'h5000,  1, 0);
    applyStimulus("stalljmp",    0, 1, 0, 0,        1, 'h7000,   0, 0, 'h84,   'h5000,  1, 0);
    applyStimulus("holdtrap",    0, 1, 0, 0,        0, 0,        1, 0, 'h80,   'h84,    1, 0);
    applyStimulus("pendcleared", 0, 0, 0, 0,        0, 0,        0, 0, 'h84,   'h84,    1, 0);
    applyStimulus("stallplain",  0, 1, 0, 0,        0, 0,        0, 0, 'h84,   'h84,    1, 0);
    applyStimulus("unstall",     0, 0, 0, 0,        0, 0,        0, 0, 'h88,   'h84,    1, 0);

    @(negedge Clk); #2 rst8 = 1; rst32 = 0;
    applyStimulus("boot8",       1, 0, 0, 0,        0, 0,        0, 0, 'hF8,   0,       1, 0);
    applyStimulus("inc8fc",      1, 0, 0, 0,        0, 0,        0, 0, 'hFC,   0,       1, 0);
    applyStimulus("wrap00",      1, 0, 0, 0,        0, 0,        0, 0, 'h00,   0,       1, 0);
    applyStimulus("inc804",      1, 0, 0, 0,        0, 0,        0, 0, 'h04,   0,       1, 0);
    applyStimulus("hold8",       1, 1, 0, 0,        1, 'h40,     0, 0, 'h04,   0,       1, 0);
    Jump = 0;
    @(posedge Clk); #2 rst8 = 0;
    pushExp("asyncrst8", 1, 'hF8, 0, 0, 0);
    applyStimulus("inrst8",      1, 0, 0, 0,        0, 0,        0, 0, 'hF8,   0,       0, 0);
    @(negedge Clk); #2 rst8 = 1;
    applyStimulus("reboot8",     1, 0, 0, 0,        0, 0,        0, 0, 'hF8,   0,       1, 0);
    applyStimulus("nopend8",     1, 0, 0, 0,        0, 0,        0, 0, 'hFC,   0,       1, 0);

    @(negedge Clk); #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: queued=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
